omok_turn_ctrl: RTL and testbench

//  Move sequencer for the 10x10 OMOK board. Turns put/undo button edges into single-cycle

---
 rtl/omok_turn_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_omok_turn_ctrl.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/omok_turn_ctrl.sv
// omok_turn_ctrl
//  Move sequencer for the 10x10 OMOK board. Converts put/undo button edges into
//  single-cycle board writes, alternates black/white turns, keeps an undo history
//  stack and runs a start/done handshake with the win-check engine. Also owns
//  game_over / winner / draw detection.
//
//  Ports
//   clk, rst          clock; synchronous active-low reset
//   put, undo         button levels, acted on at their rising edge
//   cur_pos           cursor position (row*10+col)
//   cell_state        board contents at cur_pos (00 empty, 10 black, 11 white)
//   wr_en/pos/data    board write port, one strobe per move or undo
//   chk_start         1-cycle pulse starting the win check
//   chk_pos/color     last placed stone, held for the win-check engine
//   chk_done/chk_win  win-check result (chk_win valid with chk_done)
//   turn              0 black to move, 1 white to move
//   move_count        stones on the board
//   busy              WRITE/CHECK/UNDO in progress; button edges are dropped
//   illegal           1-cycle pulse: put rejected
//   chk_err           sticky: a win check timed out
//   game_over, winner game finished; winner 10 black, 11 white, 00 draw
//
//  state   | meaning
//  S_IDLE  | waiting for a put or undo edge
//  S_WRITE | writing the new stone, pushing it on the history stack
//  S_CHECK | waiting for the win-check engine (bounded by CHK_TMO)
//  S_UNDO  | clearing the most recent stone, popping the stack
//  S_OVER  | game finished; only undo is accepted
module omok_turn_ctrl #(
   parameter int CELLS      = 100,
   parameter int HIST_DEPTH = 100,
   parameter int CHK_TMO    = 255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       put,
   input  logic       undo,
   input  logic [7:0] cur_pos,
   input  logic [1:0] cell_state,
   output logic       wr_en,
   output logic [7:0] wr_pos,
   output logic [1:0] wr_data,
   output logic       chk_start,
   output logic [7:0] chk_pos,
   output logic [1:0] chk_color,
   input  logic       chk_done,
   input  logic       chk_win,
   output logic       turn,
   output logic [7:0] move_count,
   output logic       busy,
   output logic       illegal,
   output logic       chk_err,
   output logic       game_over,
   output logic [1:0] winner
);

   localparam int AW = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;
   localparam int TW = $clog2(CHK_TMO + 1);
   localparam logic [7:0] CELLS_W = 8'(CELLS);
   localparam logic [1:0] BLACK = 2'b10;
   localparam logic [1:0] WHITE = 2'b11;
   localparam logic [1:0] EMPTY = 2'b00;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_CHECK,
      S_UNDO,
      S_OVER
   } state_t;

   state_t          state;
   logic            put_q;
   logic            undo_q;
   logic            undo_from_over;
   logic [TW-1:0]   tmo_cnt;
   logic [7:0]      hist [HIST_DEPTH];

   logic            put_rise;
   logic            undo_rise;
   logic            put_legal;
   logic            hist_empty;
   logic [AW-1:0]   sp;
   logic [AW-1:0]   sp_top;

   assign put_rise   = put & ~put_q;
   assign undo_rise  = undo & ~undo_q;
   assign put_legal  = (cur_pos < CELLS_W) && (cell_state == EMPTY);
   // the stack depth always equals the number of stones on the board
   assign hist_empty = (move_count == 8'd0);
   assign sp         = move_count[AW-1:0];
   assign sp_top     = sp - AW'(1);

   assign busy      = (state == S_WRITE) || (state == S_CHECK) || (state == S_UNDO);
   assign game_over = (state == S_OVER);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state          <= S_IDLE;
         put_q          <= 1'b0;
         undo_q         <= 1'b0;
         undo_from_over <= 1'b0;
         tmo_cnt        <= '0;
         wr_en          <= 1'b0;
         wr_pos         <= 8'd0;
         wr_data        <= EMPTY;
         chk_start      <= 1'b0;
         chk_pos        <= 8'd0;
         chk_color      <= EMPTY;
         turn           <= 1'b0;
         move_count     <= 8'd0;
         illegal        <= 1'b0;
         chk_err        <= 1'b0;
         winner         <= EMPTY;
      end else begin
         put_q     <= put;
         undo_q    <= undo;
         wr_en     <= 1'b0;
         chk_start <= 1'b0;
         illegal   <= 1'b0;

         case (state)
            S_IDLE: begin
               if (undo_rise && !hist_empty) begin
                  state          <= S_UNDO;
                  wr_en          <= 1'b1;
                  wr_pos         <= hist[sp_top];
                  wr_data        <= EMPTY;
                  undo_from_over <= 1'b0;
               end else if (put_rise) begin
                  if (put_legal) begin
                     // wr_pos/wr_data double as the latched move for WRITE
                     state   <= S_WRITE;
                     wr_en   <= 1'b1;
                     wr_pos  <= cur_pos;
                     wr_data <= turn ? WHITE : BLACK;
                  end else begin
                     illegal <= 1'b1;
                  end
               end
            end

            S_WRITE: begin
               hist[sp]   <= wr_pos;
               move_count <= move_count + 8'd1;
               chk_pos    <= wr_pos;
               chk_color  <= wr_data;
               chk_start  <= 1'b1;
               tmo_cnt    <= TW'(CHK_TMO);
               state      <= S_CHECK;
            end

            S_CHECK: begin
               // a timeout is resolved exactly like a no-win result
               if (chk_done || (tmo_cnt == TW'(1))) begin
                  if (!chk_done) begin
                     chk_err <= 1'b1;
                  end
                  if (chk_done && chk_win) begin
                     state  <= S_OVER;
                     winner <= chk_color;
                  end else if (move_count == CELLS_W) begin
                     state  <= S_OVER;
                     winner <= EMPTY;
                  end else begin
                     state <= S_IDLE;
                     turn  <= ~turn;
                  end
               end else begin
                  tmo_cnt <= tmo_cnt - TW'(1);
               end
            end

            S_UNDO: begin
               move_count <= move_count - 8'd1;
               if (undo_from_over) begin
                  winner <= EMPTY;
               end else begin
                  turn <= ~turn;
               end
               state <= S_IDLE;
            end

            S_OVER: begin
               if (undo_rise && !hist_empty) begin
                  state          <= S_UNDO;
                  wr_en          <= 1'b1;
                  wr_pos         <= hist[sp_top];
                  wr_data        <= EMPTY;
                  undo_from_over <= 1'b1;
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_omok_turn_ctrl.sv
// tb_omok_turn_ctrl
//  Self-checking bench for omok_turn_ctrl. A behavioural model (board array plus a
//  history queue) predicts every output each cycle; one negedge process compares
//  them, and a few literal expectations pin the model to known scenarios.
module tb_omok_turn_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       put = 1'b0;
   logic       undo = 1'b0;
   logic [7:0] cur_pos = 8'd0;
   logic [1:0] cell_state;
   logic       chk_done = 1'b0;
   logic       chk_win = 1'b0;
   logic       wr_en;
   logic [7:0] wr_pos;
   logic [1:0] wr_data;
   logic       chk_start;
   logic [7:0] chk_pos;
   logic [1:0] chk_color;
   logic       turn;
   logic [7:0] move_count;
   logic       busy;
   logic       illegal;
   logic       chk_err;
   logic       game_over;
   logic [1:0] winner;

   always #5 clk = ~clk;

   omok_turn_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .put        (put),
      .undo       (undo),
      .cur_pos    (cur_pos),
      .cell_state (cell_state),
      .wr_en      (wr_en),
      .wr_pos     (wr_pos),
      .wr_data    (wr_data),
      .chk_start  (chk_start),
      .chk_pos    (chk_pos),
      .chk_color  (chk_color),
      .chk_done   (chk_done),
      .chk_win    (chk_win),
      .turn       (turn),
      .move_count (move_count),
      .busy       (busy),
      .illegal    (illegal),
      .chk_err    (chk_err),
      .game_over  (game_over),
      .winner     (winner)
   );

   // ---------------- behavioural model ----------------
   localparam int M_IDLE  = 0;
   localparam int M_WRITE = 1;
   localparam int M_CHECK = 2;
   localparam int M_UNDO  = 3;
   localparam int M_OVER  = 4;

   logic [1:0] mboard [100];
   int  stk[$];
   int  m_mode = M_IDLE;
   bit  m_put_prev, m_undo_prev, from_over;
   int  age;
   int  e_wr_en, e_wr_pos, e_wr_data, e_chk_start, e_chk_pos, e_chk_color;
   int  e_turn, e_count, e_busy, e_illegal, e_err, e_over, e_winner;

   int  errors = 0;
   int  checks = 0;
   bit  cmp_en = 0;

   int  resp_delay = 1;
   bit  want_win = 0;
   bit  hold = 0;

   assign cell_state = (cur_pos < 8'd100) ? mboard[cur_pos[6:0]] : 2'b00;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic start_undo(input bit fo);
      m_mode    = M_UNDO;
      e_wr_en   = 1;
      e_wr_pos  = stk[$];
      e_wr_data = 0;
      from_over = fo;
   endtask

   task automatic model_step();
      bit pr, ur;
      e_wr_en = 0;
      e_chk_start = 0;
      e_illegal = 0;
      if (!rst) begin
         m_mode = M_IDLE;
         for (int i = 0; i < 100; i++) mboard[i] = 2'b00;
         stk.delete();
         m_put_prev = 0; m_undo_prev = 0; from_over = 0; age = 0;
         e_wr_pos = 0; e_wr_data = 0; e_chk_pos = 0; e_chk_color = 0;
         e_turn = 0; e_err = 0; e_winner = 0;
      end else begin
         pr = put && !m_put_prev;
         ur = undo && !m_undo_prev;
         m_put_prev = put;
         m_undo_prev = undo;
         case (m_mode)
            M_IDLE: begin
               if (ur && stk.size() > 0) start_undo(0);
               else if (pr) begin
                  if (cur_pos < 100 && mboard[cur_pos[6:0]] == 2'b00) begin
                     m_mode    = M_WRITE;
                     e_wr_en   = 1;
                     e_wr_pos  = int'(cur_pos);
                     e_wr_data = e_turn ? 3 : 2;
                  end else e_illegal = 1;
               end
            end
            M_WRITE: begin
               mboard[e_wr_pos] = 2'(e_wr_data);
               stk.push_back(e_wr_pos);
               e_chk_pos   = e_wr_pos;
               e_chk_color = e_wr_data;
               e_chk_start = 1;
               age = 0;
               m_mode = M_CHECK;
            end
            M_CHECK: begin
               age++;
               if (chk_done || age >= 255) begin
                  if (!chk_done) e_err = 1;
                  if (chk_done && chk_win) begin
                     m_mode = M_OVER; e_winner = e_chk_color;
                  end else if (stk.size() == 100) begin
                     m_mode = M_OVER; e_winner = 0;
                  end else begin
                     m_mode = M_IDLE; e_turn ^= 1;
                  end
               end
            end
            M_UNDO: begin
               mboard[stk[$]] = 2'b00;
               void'(stk.pop_back());
               if (from_over) e_winner = 0;
               else e_turn ^= 1;
               m_mode = M_IDLE;
            end
            M_OVER: begin
               if (ur && stk.size() > 0) start_undo(1);
            end
            default: m_mode = M_IDLE;
         endcase
      end
      e_count = stk.size();
      e_busy  = (m_mode == M_WRITE || m_mode == M_CHECK || m_mode == M_UNDO) ? 1 : 0;
      e_over  = (m_mode == M_OVER) ? 1 : 0;
   endtask

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("wr_en", wr_en, e_wr_en);
         chk("wr_pos", wr_pos, e_wr_pos);
         chk("wr_data", wr_data, e_wr_data);
         chk("chk_start", chk_start, e_chk_start);
         chk("chk_pos", chk_pos, e_chk_pos);
         chk("chk_color", chk_color, e_chk_color);
         chk("turn", turn, e_turn);
         chk("move_count", move_count, e_count);
         chk("busy", busy, e_busy);
         chk("illegal", illegal, e_illegal);
         chk("chk_err", chk_err, e_err);
         chk("game_over", game_over, e_over);
         chk("winner", winner, e_winner);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
      model_step();
      cmp_en = 1;
      chk_done = (m_mode == M_CHECK) && !hold && (age >= resp_delay);
      chk_win  = chk_done ? want_win : 1'($urandom_range(0, 1));
   endtask

   task automatic wait_settle();
      bit ok = 0;
      for (int i = 0; i < 400; i++) begin
         if (m_mode == M_IDLE || m_mode == M_OVER) begin
            ok = 1;
            break;
         end
         tick();
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL settle: model still busy after 400 cycles, mode %0d", m_mode);
      end
   endtask

   task automatic press_put(input int pos);
      cur_pos = 8'(pos);
      put = 1;
      tick();
      put = 0;
      tick();
      wait_settle();
   endtask

   task automatic press_undo();
      undo = 1;
      tick();
      undo = 0;
      tick();
      wait_settle();
   endtask

   task automatic do_reset();
      rst = 0;
      tick();
      tick();
      rst = 1;
      tick();
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int perm[100];
      int j, tmp, pos;

      // T1: reset values, first move latency
      rst = 0;
      tick();
      chk("t1_rst_count", move_count, 0);
      chk("t1_rst_winner", winner, 0);
      tick();
      rst = 1;
      tick();
      resp_delay = 1;
      cur_pos = 8'd44;
      put = 1;
      tick();
      chk("t1_wr_en", wr_en, 1);
      chk("t1_wr_pos", wr_pos, 44);
      chk("t1_wr_data", wr_data, 2);
      put = 0;
      tick();
      chk("t1_chk_start", chk_start, 1);
      chk("t1_chk_pos", chk_pos, 44);
      wait_settle();
      chk("t1_turn", turn, 1);
      chk("t1_count", move_count, 1);

      // T2: occupied cell
      cur_pos = 8'd44;
      put = 1;
      tick();
      chk("t2_illegal", illegal, 1);
      chk("t2_no_wr", wr_en, 0);
      put = 0;
      tick();
      chk("t2_illegal_pulse", illegal, 0);
      chk("t2_count", move_count, 1);
      chk("t2_turn", turn, 1);

      // T3: black wins with 44..48, put ignored in OVER, undo from OVER
      for (int i = 0; i < 4; i++) begin
         press_put(i);
         if (i == 3) want_win = 1;
         press_put(45 + i);
      end
      want_win = 0;
      chk("t3_over", game_over, 1);
      chk("t3_winner", winner, 2);
      chk("t3_count", move_count, 9);
      press_put(50);
      chk("t3_put_ignored", move_count, 9);
      undo = 1;
      tick();
      chk("t3_undo_wr_en", wr_en, 1);
      chk("t3_undo_pos", wr_pos, 48);
      chk("t3_undo_data", wr_data, 0);
      undo = 0;
      tick();
      wait_settle();
      chk("t3_over_clr", game_over, 0);
      chk("t3_winner_clr", winner, 0);
      chk("t3_turn", turn, 0);
      chk("t3_count2", move_count, 8);

      // T4: undo on empty stack; put+undo together
      do_reset();
      press_undo();
      chk("t4_empty_undo", move_count, 0);
      press_put(10);
      press_put(11);
      cur_pos = 8'd12;
      put = 1;
      undo = 1;
      tick();
      chk("t4_undo_pos", wr_pos, 11);
      chk("t4_undo_data", wr_data, 0);
      put = 0;
      undo = 0;
      tick();
      wait_settle();
      chk("t4_count", move_count, 1);
      chk("t4_turn", turn, 1);

      // T5: check timeout, then reset in the middle of CHECK
      do_reset();
      hold = 1;
      press_put(5);
      chk("t5_err", chk_err, 1);
      chk("t5_turn", turn, 1);
      chk("t5_count", move_count, 1);
      cur_pos = 8'd6;
      put = 1;
      tick();
      put = 0;
      repeat (10) tick();
      chk("t5_busy", busy, 1);
      rst = 0;
      tick();
      chk("t5_rst_busy", busy, 0);
      chk("t5_rst_count", move_count, 0);
      chk("t5_rst_err", chk_err, 0);
      chk("t5_rst_chkpos", chk_pos, 0);
      chk("t5_rst_turn", turn, 0);
      rst = 1;
      hold = 0;
      tick();

      // T6: fill the board in random order, no wins -> draw
      for (int i = 0; i < 100; i++) perm[i] = i;
      for (int i = 99; i > 0; i--) begin
         j = $urandom_range(0, i);
         tmp = perm[i];
         perm[i] = perm[j];
         perm[j] = tmp;
      end
      for (int i = 0; i < 100; i++) begin
         resp_delay = $urandom_range(0, 3);
         if ($urandom_range(0, 3) == 0) begin
            if (i > 0 && $urandom_range(0, 1) == 1) pos = perm[$urandom_range(0, i - 1)];
            else pos = 100 + $urandom_range(0, 155);
            press_put(pos);
         end
         press_put(perm[i]);
      end
      chk("t6_over", game_over, 1);
      chk("t6_winner", winner, 0);
      chk("t6_count", move_count, 100);
      press_put(200);
      chk("t6_still_over", game_over, 1);

      // random play against the model
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         put = ($urandom_range(0, 2) == 0);
         undo = ($urandom_range(0, 6) == 0);
         cur_pos = 8'($urandom_range(0, 104));
         want_win = ($urandom_range(0, 9) == 0);
         resp_delay = $urandom_range(0, 4);
         rst = ($urandom_range(0, 499) != 0);
         tick();
      end
      rst = 1;
      put = 0;
      undo = 0;
      tick();
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
